// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared definitions for the multi-cycle multiply/divide engine.
//   - MCycleOp bit encodings (bit0 selects multiply/divide, bit1 selects
//     unsigned/signed arithmetic).
//   - FSM state encoding used by mcycle_unit.
package mcycle_pkg;

  // MCycleOp[0]
  localparam logic MCOP_MUL      = 1'b0;
  localparam logic MCOP_DIV      = 1'b1;
  // MCycleOp[1]
  localparam logic MCOP_UNSIGNED = 1'b0;
  localparam logic MCOP_SIGNED   = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/mcycle_unit_if.sv
// mcycle_unit_if: request/response bundle between the EX stage and the
// multi-cycle engine.
//   Start     EX-stage instruction is a multi-cycle op (held while stalled)
//   MCycleOp  bit0: 0=multiply 1=divide; bit1: 0=unsigned 1=signed
//   Operand1  multiplicand / dividend
//   Operand2  multiplier / divisor
//   Result1   product low half / quotient
//   Result2   product high half / remainder
//   Busy      stall request to the hazard unit
//   Done      one-cycle pulse, results valid this cycle
// Modports: master = pipeline side, slave = engine side.
interface mcycle_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mcycle_div_step.sv
// mcycle_div_step: one combinational restoring-division iteration.
//   i_rem      current partial remainder (always < divisor)
//   i_dbit     next dividend bit, shifted into the remainder LSB
//   i_divisor  divisor magnitude
//   o_rem      next partial remainder
//   o_qbit     quotient bit produced by this iteration
module mcycle_div_step
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dbit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  // Shifted remainder needs one extra bit before the compare.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  assign w_shift = {i_rem, i_dbit};
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});
  // When the subtraction succeeds the true difference is below the divisor,
  // so a WIDTH-bit modular subtract gives the exact value.
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
  // On failure the shifted value is below the divisor and fits in WIDTH bits.
  assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative multiply/divide engine for the EX stage.
//   CLK    system clock, all state on the rising edge
//   RESET  synchronous active-high reset; aborts any operation in flight
//   bus    mcycle_unit_if.slave (Start/MCycleOp/Operand1/Operand2 in,
//          Result1/Result2/Busy/Done out)
// Operation: Start in IDLE latches the op and operand magnitudes, COMPUTE
// runs WIDTH shift-add or restoring-divide iterations, the last iteration
// applies the sign fix and registers the results, DONE pulses Done for one
// cycle. Busy = (IDLE & Start) | COMPUTE.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  mcycle_unit_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_op_kind;     // MCOP_MUL / MCOP_DIV
  logic                 r_sign_q;      // negate product / quotient
  logic                 r_sign_r;      // negate remainder
  logic                 r_div_zero;
  logic [WIDTH-1:0]     r_a;           // multiplier, or dividend shifting into quotient
  logic [WIDTH-1:0]     r_b;           // divisor magnitude
  logic [2*WIDTH-1:0]   r_acc;         // product accumulator, low half = remainder
  logic [2*WIDTH-1:0]   r_mcand;       // multiplicand, shifted left each step
  logic [WIDTH-1:0]     r_result1;
  logic [WIDTH-1:0]     r_result2;
  logic                 r_done;

  logic                 w_signed;
  logic [WIDTH-1:0]     w_op1_abs;
  logic [WIDTH-1:0]     w_op2_abs;
  logic [2*WIDTH-1:0]   w_prod_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_rem_next;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_quo_next;
  logic [WIDTH-1:0]     w_res1;
  logic [WIDTH-1:0]     w_res2;

  // Magnitudes: the most-negative value negates to itself, which read as
  // unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
  assign w_signed  = (bus.MCycleOp[1] == MCOP_SIGNED);
  assign w_op1_abs = (w_signed && bus.Operand1[WIDTH-1]) ? -bus.Operand1 : bus.Operand1;
  assign w_op2_abs = (w_signed && bus.Operand2[WIDTH-1]) ? -bus.Operand2 : bus.Operand2;

  // Multiply step: LSB-first shift-add.
  assign w_prod_next = r_acc + (r_a[0] ? r_mcand : '0);

  // Divide step: dividend MSB feeds the remainder, quotient bit enters r_a LSB.
  mcycle_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem     (r_acc[WIDTH-1:0]),
    .i_dbit    (r_a[WIDTH-1]),
    .i_divisor (r_b),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  assign w_quo_next = {r_a[WIDTH-2:0], w_qbit};

  // Sign fix applied to the final iteration's values.
  always_comb begin
    w_prod_fix = w_prod_next;
    w_res1     = '0;
    w_res2     = '0;
    if (r_op_kind == MCOP_MUL) begin
      if (r_sign_q) w_prod_fix = -w_prod_next;
      w_res1 = w_prod_fix[WIDTH-1:0];
      w_res2 = w_prod_fix[2*WIDTH-1:WIDTH];
    end else begin
      w_res1 = r_sign_q ? -w_quo_next : w_quo_next;
      // The remainder of a divide by zero is |Op1| re-signed, i.e. Op1 itself.
      w_res2 = r_sign_r ? -w_rem_next : w_rem_next;
      // Quotient for a zero divisor is all ones regardless of signs.
      if (r_div_zero) w_res1 = '1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op_kind  <= MCOP_MUL;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_div_zero <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_result1  <= '0;
      r_result2  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_op_kind  <= bus.MCycleOp[0];
            r_sign_q   <= w_signed & (bus.Operand1[WIDTH-1] ^ bus.Operand2[WIDTH-1]);
            r_sign_r   <= w_signed & bus.Operand1[WIDTH-1];
            r_div_zero <= (bus.Operand2 == '0);
            r_a        <= (bus.MCycleOp[0] == MCOP_DIV) ? w_op1_abs : w_op2_abs;
            r_b        <= w_op2_abs;
            r_mcand    <= {{WIDTH{1'b0}}, w_op1_abs};
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (r_op_kind == MCOP_DIV) begin
            r_acc <= {{WIDTH{1'b0}}, w_rem_next};
            r_a   <= w_quo_next;
          end else begin
            r_acc   <= w_prod_next;
            r_mcand <= r_mcand << 1;
            r_a     <= r_a >> 1;
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_result1 <= w_res1;
            r_result2 <= w_res2;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        // The stalled instruction advances on this edge, so Start is ignored.
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Busy    = ((r_state == IDLE) && bus.Start) || (r_state == COMPUTE);
  assign bus.Done    = r_done;
  assign bus.Result1 = r_result1;
  assign bus.Result2 = r_result2;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed self-checking bench for mcycle_unit (WIDTH=32).
module tb_mcycle_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mcycle_unit_if #(.WIDTH(32)) u_if ();

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 of the issue cycle; returns at posedge+1 of the
  // Done cycle with Start still held high.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2);
    int lat;
    int busy_cycles;
    bit seen;
    u_if.Start    = 1'b1;
    u_if.MCycleOp = op;
    u_if.Operand1 = a;
    u_if.Operand2 = b;
    #1;
    check({tag, " busy_at_start"}, {31'd0, u_if.Busy}, 32'd1);
    lat = 0;
    busy_cycles = 1;
    seen = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        // Operands change while computing; only latched copies may matter.
        u_if.Operand1 = ~a;
        u_if.Operand2 = a ^ b ^ 32'h5A5A_0001;
        u_if.MCycleOp = ~op;
      end
      if (u_if.Done) begin
        seen = 1;
        break;
      end
      if (u_if.Busy) busy_cycles++;
    end
    check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"}, lat, 32'd33);
    check({tag, " busy_cycles"}, busy_cycles, 32'd33);
    check({tag, " busy_in_done"}, {31'd0, u_if.Busy}, 32'd0);
    check({tag, " result1"}, u_if.Result1, e1);
    check({tag, " result2"}, u_if.Result2, e2);
    $display("op %s: op=%b a=%h b=%h -> r1=%h r2=%h lat=%0d", tag, op, a, b,
             u_if.Result1, u_if.Result2, lat);
  endtask

  // Leaves the Done cycle with Start held, then drops Start in IDLE.
  task automatic idle_after(input string tag, input logic [31:0] e1, input logic [31:0] e2);
    @(posedge clk); #1;
    u_if.Start = 1'b0;
    #1;
    check({tag, " no_retrigger_busy"}, {31'd0, u_if.Busy}, 32'd0);
    check({tag, " done_one_cycle"}, {31'd0, u_if.Done}, 32'd0);
    check({tag, " hold_r1"}, u_if.Result1, e1);
    check({tag, " hold_r2"}, u_if.Result2, e2);
    @(posedge clk); #1;
  endtask

  initial begin
    int pulses;
    u_if.Start    = 1'b0;
    u_if.MCycleOp = 2'b00;
    u_if.Operand1 = '0;
    u_if.Operand2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, u_if.Busy}, 32'd0);
    check("reset done", {31'd0, u_if.Done}, 32'd0);
    check("reset r1", u_if.Result1, 32'd0);
    check("reset r2", u_if.Result2, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("umul", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0001);
    idle_after("umul", 32'hFFFF_FFFE, 32'h0000_0001);

    run_op("smul", 2'b10, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    // Back-to-back: Start stays high into IDLE and issues straight away.
    @(posedge clk); #1;
    run_op("sdiv", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    idle_after("sdiv", 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    run_op("udiv0", 2'b01, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678);
    idle_after("udiv0", 32'hFFFF_FFFF, 32'h1234_5678);

    run_op("sovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    idle_after("sovf", 32'h8000_0000, 32'h0000_0000);

    run_op("sdiv0", 2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    idle_after("sdiv0", 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    run_op("udiv", 2'b01, 32'd100, 32'd7, 32'd14, 32'd2);
    idle_after("udiv", 32'd14, 32'd2);

    run_op("sdiv_negb", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    idle_after("sdiv_negb", 32'hFFFF_FFFD, 32'd1);

    run_op("smul_negneg", 2'b10, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15, 32'd0);
    idle_after("smul_negneg", 32'd15, 32'd0);

    run_op("umul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    idle_after("umul_max", 32'h0000_0001, 32'hFFFF_FFFE);

    run_op("smul_minmin", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000);
    idle_after("smul_minmin", 32'h0000_0000, 32'h4000_0000);

    // Reset mid-operation: start a multiply, reset at t+10.
    u_if.Start    = 1'b1;
    u_if.MCycleOp = 2'b00;
    u_if.Operand1 = 32'h0000_1234;
    u_if.Operand2 = 32'h0000_5678;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    u_if.Start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset busy", {31'd0, u_if.Busy}, 32'd0);
    check("midreset done", {31'd0, u_if.Done}, 32'd0);
    check("midreset r1", u_if.Result1, 32'd0);
    check("midreset r2", u_if.Result2, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (u_if.Done) pulses++;
    end
    check("midreset no_done", pulses, 32'd0);
    $display("op midreset: done pulses after abort=%0d", pulses);

    // Engine still usable after the abort.
    run_op("after_reset", 2'b01, 32'd1000, 32'd10, 32'd100, 32'd0);
    idle_after("after_reset", 32'd100, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Multi-cycle multiply/divide engine for the EX stage. It handles MUL/UMULL/SMULL-class and SDIV/UDIV-class instructions.
- An internal FSM sequences an iterative shift-add multiplier or restoring divider.
- Busy feeds the hazard unit, which stalls F/D/E and bubbles E->M until the result is ready.
- Results are written back through the normal M/W path in the cycle Busy falls.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 4 and even.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- Start  input  1  EX-stage instruction is a multi-cycle op; held high by the stalled pipeline.
- MCycleOp  input  2  bit0: 0=multiply, 1=divide; bit1: 0=unsigned, 1=signed.
- Operand1  input  WIDTH  multiplicand / dividend.
- Operand2  input  WIDTH  multiplier / divisor.
- Result1  output  WIDTH  product low half / quotient.
- Result2  output  WIDTH  product high half / remainder.
- Busy  output  1  stall request to the hazard unit.
- Done  output  1  one-cycle pulse: results valid this cycle.

Behaviour:
- Reset: state=IDLE; Result1=0, Result2=0, Done=0; Busy=0. An asserted RESET mid-operation aborts immediately, and no Done is produced.
- States: IDLE, COMPUTE, DONE.
- IDLE: on Start=1, latch MCycleOp and the operands.
  - If signed, latch the absolute values, plus sign_q=Op1[msb]^Op2[msb] and sign_r=Op1[msb].
  - Clear the iteration counter and go to COMPUTE.
- COMPUTE: one iteration per cycle, exactly WIDTH cycles (counter 0..WIDTH-1, width clog2(WIDTH)).
  - Multiply: 2*WIDTH-bit shift-add, LSB-first.
  - Divide: restoring step. Shift the remainder left by one and bring in the dividend MSB. Subtract the divisor; if the result is non-negative, keep it and set quotient bit=1, else restore.
  - On the last iteration, apply the sign fix and register Result1/Result2, then go to DONE.
- Sign fix:
  - Signed multiply: negate the 2*WIDTH product if sign_q.
  - Signed divide: negate the quotient if sign_q, negate the remainder if sign_r.
  - Unsigned: no change.
- DONE: Done=1 for exactly one cycle; Busy=0. Start is ignored here, because the stalled instruction advances this edge. Next state is IDLE unconditionally.
- Busy (combinational) = (IDLE & Start) | COMPUTE. It is high from the Start cycle through the last COMPUTE cycle: WIDTH+1 cycles total.
- Latency: Start seen at cycle t, so Done=1 and results valid at cycle t+WIDTH+1.
- Results hold their value until the next operation completes; they are not cleared in IDLE.
- Operand/Op changes while in COMPUTE are ignored; only the latched copies are used.
- Divide by zero: Quotient = all ones (unsigned and signed). Remainder = Operand1 unmodified (original signed value).
- Signed overflow (most-negative / -1): Quotient = most-negative, Remainder = 0. This falls out of the magnitude algorithm plus negation modulo 2^WIDTH.
- The magnitude of the most-negative value is treated as an unsigned 2^(WIDTH-1); no extra bit is needed.
- Back-to-back ops: after DONE->IDLE, a new Start in IDLE begins immediately. The minimum issue interval is WIDTH+2 cycles.

Decomposition:
- mcycle_pkg holds:
  - localparams MCOP_MUL=0 / MCOP_DIV=1 for bit0 and MCOP_UNSIGNED=0 / MCOP_SIGNED=1 for bit1;
  - state encoding IDLE=2'd0, COMPUTE=2'd1, DONE=2'd2.
- One sub-module, mcycle_div_step: purely combinational single restoring-division iteration.
  - Inputs: rem, dividend bit, divisor.
  - Outputs: next rem, quotient bit.
- The multiply step and the sign fix stay inline.

Test Plan:
- Unsigned multiply, WIDTH=32: Op1=0xFFFFFFFF, Op2=0x00000002, MCycleOp=2'b00 -> Busy high 33 cycles; Done at t+33; Result2=0x00000001, Result1=0xFFFFFFFE.
- Signed multiply: Op1=-3 (0xFFFFFFFD), Op2=7, MCycleOp=2'b10 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFEB (-21).
- Signed divide: Op1=-7, Op2=2, MCycleOp=2'b11 -> Result1=0xFFFFFFFD (-3), Result2=0xFFFFFFFF (-1).
- Divide by zero: Op1=0x12345678, Op2=0, MCycleOp=2'b01 -> Result1=0xFFFFFFFF, Result2=0x12345678.
- Signed overflow: Op1=0x80000000, Op2=0xFFFFFFFF, MCycleOp=2'b11 -> Result1=0x80000000, Result2=0.
- Reset and Start handling:
  - RESET asserted at t+10 of a multiply -> next cycle Busy=0, Done=0, Result1=Result2=0, state IDLE; no Done pulse follows.
  - Start held high through DONE -> no re-trigger in DONE; re-issue only from IDLE.
